dmem_stream_ctrl: RTL and testbench

- Initiator-side controller for the byte-wide data memory. Moves a contiguous block of bytes between a byte stream and memory.
- LOAD mode: consumes bytes from an input valid/ready stream and issues memory writes.
- DUMP mode: issues memory reads and presents each byte on an output valid/ready stream.
- Used for test-vector preload and result readout around program execution. It owns the memory port only while busy.

---
 rtl/dmem_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_dmem_stream_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stream_ctrl.sv
// dmem_stream_ctrl
// Initiator-side controller for the byte-wide data memory. Moves a contiguous
// block of bytes between a byte stream and memory, and drives the memory port
// only while busy.
//   LOAD (dir=0): accepts in_valid/in_data bytes and writes them to memory.
//   DUMP (dir=1): reads memory (combinational read) and presents each byte on
//                 out_valid/out_data, advancing on out_ready.
// Ports:
//   clk, reset (synchronous, active-low)
//   start, dir, base_addr, length     block request, sampled only in IDLE
//   in_valid, in_data, in_ready       input byte stream
//   out_valid, out_data, out_ready    output byte stream
//   MemAddr, MemWriteEn, MemWriteData, MemReadSel, MemReadData   memory port
//   busy                              high while in LOAD or DUMP
//   done                              one-cycle pulse after a block completes
module dmem_stream_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned LEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [W-1:0]     base_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [W-1:0]     MemAddr,
  output logic             MemWriteEn,
  output logic [W-1:0]     MemWriteData,
  output logic             MemReadSel,
  input  logic [W-1:0]     MemReadData,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLoad, StDump} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    done_d       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    MemAddr      = '0;
    MemWriteEn   = 1'b0;
    MemWriteData = '0;
    MemReadSel   = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = length;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = dir ? StDump : StLoad;
          end
        end
      end

      StLoad: begin
        busy         = 1'b1;
        // Gating with reset keeps an abandoned block from writing at the reset edge.
        in_ready     = reset;
        MemAddr      = addr_q;
        MemWriteData = in_data;
        MemWriteEn   = in_valid & reset;
        if (in_valid) begin
          addr_d = addr_q + W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      StDump: begin
        busy       = 1'b1;
        MemReadSel = 1'b1;
        MemAddr    = addr_q;
        out_valid  = 1'b1;
        // addr only moves on out_ready, so out_data holds steady while stalled.
        out_data   = MemReadData;
        if (out_ready) begin
          addr_d = addr_q + W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_dmem_stream_ctrl.sv
// Self-checking bench for dmem_stream_ctrl. A behavioural byte memory sits on
// the memory port; expected writes and expected output bytes are queued when
// stimulus is driven and popped when the DUT performs them.
module tb_dmem_stream_ctrl;
  localparam int unsigned W     = 8;
  localparam int unsigned LEN_W = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             dir;
  logic [W-1:0]     base_addr;
  logic [LEN_W-1:0] length;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [W-1:0]     MemAddr;
  logic             MemWriteEn;
  logic [W-1:0]     MemWriteData;
  logic             MemReadSel;
  logic [W-1:0]     MemReadData;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  dmem_stream_ctrl #(.W(W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dir         (dir),
    .base_addr   (base_addr),
    .length      (length),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .MemAddr     (MemAddr),
    .MemWriteEn  (MemWriteEn),
    .MemWriteData(MemWriteData),
    .MemReadSel  (MemReadSel),
    .MemReadData (MemReadData),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural memory with a side port for preloading.
  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (MemWriteEn === 1'b1) mem[MemAddr] <= MemWriteData;
  end
  assign MemReadData = mem[MemAddr];

  int         checks;
  int         errors;
  int         done_cnt;
  int         d0;
  logic [15:0] wq [$];  // {addr, data} of expected writes
  logic [7:0]  dq [$];  // expected output-stream bytes

  typedef struct packed {
    logic       start;
    logic       dir;
    logic [7:0] base;
    logic [8:0] len;
    logic       iv;
    logic [7:0] idata;
    logic       exp_ir;
    logic       exp_we;
    logic [7:0] exp_addr;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t ld_tab [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [15:0] w;
    logic [7:0]  b;
    if (MemWriteEn === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 32'(MemWriteEn), 32'(0));
      else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(MemAddr), 32'(w[15:8]));
        chk("wr_data", 32'(MemWriteData), 32'(w[7:0]));
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_out", 32'(out_valid), 32'(0));
      else begin
        b = dq.pop_front();
        chk("out_byte", 32'(out_data), 32'(b));
      end
    end
    chk("busy_done_excl", 32'(busy & done), 32'(0));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    at_neg();
    to_pos();
    pre_we   = 1'b0;
  endtask

  task automatic cycle();
    at_neg();
    to_pos();
  endtask

  initial begin
    logic       rp [6];
    logic [7:0] wrap_a [3];
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;

    //             st dir base   len    iv idata  ir we addr   bsy dn
    ld_tab[0] = '{1'b1, 1'b0, 8'h10, 9'd4, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    ld_tab[1] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b1, 8'hA1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0};
    ld_tab[2] = '{1'b1, 1'b0, 8'h80, 9'd0, 1'b0, 8'hEE, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    ld_tab[3] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b1, 8'hB2, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    ld_tab[4] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b1, 8'hC3, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
    ld_tab[5] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0};
    ld_tab[6] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b1, 8'hD4, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0};
    ld_tab[7] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    ld_tab[8] = '{1'b0, 1'b0, 8'h00, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset held for two edges with start and in_valid asserted.
    reset = 1'b0; start = 1'b1; dir = 1'b0; base_addr = 8'h55; length = 9'd4;
    in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    to_pos();
    at_neg();
    chk("rst_ctl_c1", 32'({in_ready, out_valid, MemWriteEn, MemReadSel, busy, done}), 32'(0));
    chk("rst_bus_c1", 32'({MemAddr, MemWriteData, out_data}), 32'(0));
    to_pos();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    at_neg();
    chk("rst_ctl_rel", 32'({in_ready, out_valid, MemWriteEn, MemReadSel, busy, done}), 32'(0));
    chk("rst_bus_rel", 32'({MemAddr, MemWriteData, out_data}), 32'(0));
    to_pos();
    cycle();
    chk("rst_no_done", 32'(done_cnt), 32'(0));

    // LOAD 4 bytes at 0x10 with gaps; a start mid-block must be ignored.
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) begin
      start     = ld_tab[i].start;
      dir       = ld_tab[i].dir;
      base_addr = ld_tab[i].base;
      length    = ld_tab[i].len;
      in_valid  = ld_tab[i].iv;
      in_data   = ld_tab[i].idata;
      if (ld_tab[i].exp_we) wq.push_back({ld_tab[i].exp_addr, ld_tab[i].idata});
      at_neg();
      chk($sformatf("ld%0d_in_ready", i), 32'(in_ready), 32'(ld_tab[i].exp_ir));
      chk($sformatf("ld%0d_we", i), 32'(MemWriteEn), 32'(ld_tab[i].exp_we));
      chk($sformatf("ld%0d_addr", i), 32'(MemAddr), 32'(ld_tab[i].exp_addr));
      chk($sformatf("ld%0d_busy", i), 32'(busy), 32'(ld_tab[i].exp_busy));
      chk($sformatf("ld%0d_done", i), 32'(done), 32'(ld_tab[i].exp_done));
      to_pos();
    end
    start = 1'b0; in_valid = 1'b0;
    chk("ld_done_once", 32'(done_cnt - d0), 32'(1));
    chk("ld_wq_empty", 32'(wq.size()), 32'(0));
    chk("ld_mem10", 32'(mem[8'h10]), 32'(8'hA1));
    chk("ld_mem11", 32'(mem[8'h11]), 32'(8'hB2));
    chk("ld_mem12", 32'(mem[8'h12]), 32'(8'hC3));
    chk("ld_mem13", 32'(mem[8'h13]), 32'(8'hD4));

    // DUMP 3 bytes with backpressure.
    preload(8'h20, 8'h11);
    preload(8'h21, 8'h22);
    preload(8'h22, 8'h33);
    dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33);
    start = 1'b1; dir = 1'b1; base_addr = 8'h20; length = 9'd3;
    at_neg();
    chk("dmp_idle_busy", 32'(busy), 32'(0));
    to_pos();
    start = 1'b0;
    rp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      out_ready = rp[i];
      at_neg();
      chk($sformatf("dmp%0d_valid", i), 32'(out_valid), 32'(1));
      chk($sformatf("dmp%0d_sel", i), 32'(MemReadSel), 32'(1));
      chk($sformatf("dmp%0d_we", i), 32'(MemWriteEn), 32'(0));
      if (!rp[i] && dq.size() > 0) chk($sformatf("dmp%0d_hold", i), 32'(out_data), 32'(dq[0]));
      to_pos();
    end
    out_ready = 1'b0;
    at_neg();
    chk("dmp_done", 32'(done), 32'(1));
    chk("dmp_valid_off", 32'(out_valid), 32'(0));
    chk("dmp_dq_empty", 32'(dq.size()), 32'(0));
    to_pos();

    // LOAD across the address wrap.
    wrap_a = '{8'hFE, 8'hFF, 8'h00};
    start = 1'b1; dir = 1'b0; base_addr = 8'hFE; length = 9'd3;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      wq.push_back({wrap_a[i], 8'(i + 1)});
      cycle();
    end
    in_valid = 1'b0;
    at_neg();
    chk("wrap_done", 32'(done), 32'(1));
    chk("wrap_wq_empty", 32'(wq.size()), 32'(0));
    to_pos();
    chk("wrap_memFE", 32'(mem[8'hFE]), 32'(8'h01));
    chk("wrap_memFF", 32'(mem[8'hFF]), 32'(8'h02));
    chk("wrap_mem00", 32'(mem[8'h00]), 32'(8'h03));

    // Zero-length request.
    start = 1'b1; dir = 1'b1; base_addr = 8'h30; length = 9'd0;
    at_neg();
    chk("zl_busy0", 32'(busy), 32'(0));
    to_pos();
    start = 1'b0;
    at_neg();
    chk("zl_done", 32'(done), 32'(1));
    chk("zl_busy1", 32'(busy), 32'(0));
    to_pos();
    at_neg();
    chk("zl_done_off", 32'(done), 32'(0));
    chk("zl_busy2", 32'(busy), 32'(0));
    to_pos();

    // Reset in the middle of an 8-byte DUMP, then a fresh block.
    for (int i = 0; i < 8; i++) preload(8'(8'h40 + i), 8'(8'h60 + i));
    dq.push_back(8'h60); dq.push_back(8'h61); dq.push_back(8'h62);
    start = 1'b1; dir = 1'b1; base_addr = 8'h40; length = 9'd8;
    cycle();
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b0; reset = 1'b0;
    d0 = done_cnt;
    cycle();
    reset = 1'b1;
    at_neg();
    chk("rd_valid_off", 32'(out_valid), 32'(0));
    chk("rd_busy_off", 32'(busy), 32'(0));
    to_pos();
    cycle();
    chk("rd_no_done", 32'(done_cnt - d0), 32'(0));
    chk("rd_dq_empty", 32'(dq.size()), 32'(0));
    dq.push_back(8'h64); dq.push_back(8'h65);
    start = 1'b1; dir = 1'b1; base_addr = 8'h44; length = 9'd2;
    cycle();
    start = 1'b0;
    at_neg();
    chk("rd_fresh_addr", 32'(MemAddr), 32'(8'h44));
    to_pos();
    out_ready = 1'b1;
    cycle();
    cycle();
    out_ready = 1'b0;
    at_neg();
    chk("rd_fresh_done", 32'(done), 32'(1));
    chk("rd_fresh_dq", 32'(dq.size()), 32'(0));
    to_pos();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
